// File: rtl/slice_config_loader.sv
// Serial configuration loader for one logic slice.
// Shifts a PAYLOAD_BITS-long bitstream plus one even-parity bit into a shadow
// register, then copies it to the slice-facing output registers and pulses cen
// for one cycle. A parity failure parks the loader in an error state and leaves
// the previously committed configuration untouched.
module slice_config_loader #(
  parameter int unsigned S_XX_BASE = 4,
  parameter int unsigned NUM_LUTS  = 4,
  parameter int unsigned CFG_SIZE  = 2**S_XX_BASE + 1,
  parameter int unsigned MUX_LVLS  = $clog2(NUM_LUTS)
) (
  input  logic                             cclk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             cfg_bit,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  output logic [2*CFG_SIZE*NUM_LUTS-1:0]   luts_config_out,
  output logic [MUX_LVLS-1:0]              inter_lut_mux_config,
  output logic                             config_use_cc,
  output logic                             cen,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int unsigned LUT_BITS     = 2 * CFG_SIZE * NUM_LUTS;
  localparam int unsigned PAYLOAD_BITS = LUT_BITS + MUX_LVLS + 1;
  localparam int unsigned CNT_W        = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StParity,
    StCommit,
    StError
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0] shadow_q, shadow_d;
  logic [PAYLOAD_BITS-1:0] out_q, out_d;
  logic                    par_q, par_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    accept;

  // State register; rst wins over everything else.
  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: counter, shadow, running parity, committed config, flags.
  always_ff @(posedge cclk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      par_q    <= par_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update; abort overrides start and any accepted bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    par_d    = par_q;
    done_d   = done_q;
    err_d    = err_q;
    accept   = cfg_valid && ((state_q == StLoad) || (state_q == StParity));

    if (abort) begin
      state_d  = StIdle;
      cnt_d    = '0;
      shadow_d = '0;
      par_d    = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StError: begin
          if (start) begin
            state_d = StLoad;
            cnt_d   = '0;
            par_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        StLoad: begin
          if (accept) begin
            // First stream bit ends up in the MSB after PAYLOAD_BITS shifts.
            shadow_d = {shadow_q[PAYLOAD_BITS-2:0], cfg_bit};
            par_d    = par_q ^ cfg_bit;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
              state_d = StParity;
            end
          end
        end
        StParity: begin
          if (accept) begin
            if (par_q ^ cfg_bit) begin
              state_d = StError;
              err_d   = 1'b1;
            end else begin
              // Outputs update on the same edge that enters COMMIT.
              state_d = StCommit;
              out_d   = shadow_q;
            end
          end
        end
        StCommit: begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Handshake, status and slice-facing outputs.
  always_comb begin
    cfg_ready            = (state_q == StLoad) || (state_q == StParity);
    busy                 = (state_q == StLoad) || (state_q == StParity) ||
                           (state_q == StCommit);
    cen                  = (state_q == StCommit);
    done                 = done_q;
    error                = err_q;
    config_use_cc        = out_q[PAYLOAD_BITS-1];
    inter_lut_mux_config = out_q[PAYLOAD_BITS-2 -: MUX_LVLS];
    luts_config_out      = out_q[LUT_BITS-1:0];
  end

endmodule

// File: tb/tb_slice_config_loader.sv
// Self-checking bench for slice_config_loader: randomized bitstreams checked
// against a stream-level model of the committed word and parity rule.
module tb_slice_config_loader;

  localparam int unsigned S_XX_BASE = 4;
  localparam int unsigned NUM_LUTS  = 4;
  localparam int unsigned CFG_SIZE  = 17;
  localparam int unsigned MUX_LVLS  = 2;
  localparam int unsigned LB        = 2 * CFG_SIZE * NUM_LUTS;
  localparam int unsigned P         = LB + MUX_LVLS + 1;

  logic          cclk = 1'b0;
  logic          rst = 1'b0, start = 1'b0, abort = 1'b0, cfg_bit = 1'b0, cfg_valid = 1'b0;
  logic          cfg_ready, config_use_cc, cen, busy, done, error;
  logic [LB-1:0] luts_config_out;
  logic [MUX_LVLS-1:0] inter_lut_mux_config;
  logic [P-1:0]  dut_word;

  int checks = 0;
  int failures = 0;
  int cen_count = 0;
  int accepted = 0;
  logic [P-1:0] cen_word = '0;
  logic [P-1:0] exp_word = '0;
  logic stream[$];

  slice_config_loader #(
    .S_XX_BASE(S_XX_BASE),
    .NUM_LUTS (NUM_LUTS),
    .CFG_SIZE (CFG_SIZE),
    .MUX_LVLS (MUX_LVLS)
  ) dut (
    .cclk                (cclk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .cfg_bit             (cfg_bit),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .luts_config_out     (luts_config_out),
    .inter_lut_mux_config(inter_lut_mux_config),
    .config_use_cc       (config_use_cc),
    .cen                 (cen),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  always #5 cclk = ~cclk;

  assign dut_word = {config_use_cc, inter_lut_mux_config, luts_config_out};

  // Count capture strobes and remember what the slice would have captured.
  always @(negedge cclk) begin
    if (cen === 1'b1) begin
      cen_count++;
      cen_word = dut_word;
    end
  end

  // Model: stream bit k occupies word bit P-1-k.
  function automatic logic [P-1:0] model_word();
    logic [P-1:0] w = '0;
    for (int k = 0; k < P; k++) w[P-1-k] = stream[k];
    return w;
  endfunction

  // Model: even parity bit over the whole payload.
  function automatic logic model_parity();
    logic p = 1'b0;
    foreach (stream[k]) p ^= stream[k];
    return p;
  endfunction

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic rand_stream();
    stream.delete();
    for (int k = 0; k < P; k++) stream.push_back(1'($urandom_range(1, 0)));
  endtask

  task automatic gap(input bit gaps);
    int n = 0;
    while (gaps && ($urandom_range(1, 0) == 1) && (n < 8)) begin
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom_range(1, 0));
      tick();
      n++;
    end
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    cfg_bit   = b;
    cfg_valid = 1'b1;
    while ((cfg_ready !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    if (cfg_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_bit_timeout: cfg_ready=%b required 1", cfg_ready);
    end else begin
      tick();
      accepted++;
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'($urandom_range(1, 0));
  endtask

  task automatic send_stream(input bit gaps, input logic par);
    foreach (stream[k]) begin
      gap(gaps);
      send_bit(stream[k]);
    end
    gap(gaps);
    send_bit(par);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_word = '0;
    checks++;
    if (dut_word !== exp_word) begin
      failures++;
      $display("FAIL reset_word: got %h required %h", dut_word, exp_word);
    end
    checks++;
    if ({cfg_ready, cen, busy, done, error} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: ready/cen/busy/done/error=%b required 00000",
               {cfg_ready, cen, busy, done, error});
    end
  endtask

  task automatic test_single_bit();
    stream.delete();
    stream.push_back(1'b1);
    for (int k = 1; k < P; k++) stream.push_back(1'b0);
    exp_word  = model_word();
    cen_count = 0;
    do_start();
    checks++;
    if ({busy, cfg_ready} !== 2'b11) begin
      failures++;
      $display("FAIL load_flags: busy/ready=%b required 11", {busy, cfg_ready});
    end
    send_stream(1'b0, 1'b1);
    checks++;
    if ((cen !== 1'b1) || (dut_word !== exp_word)) begin
      failures++;
      $display("FAIL commit_cycle: cen=%b word=%h required cen=1 word=%h", cen, dut_word,
               exp_word);
    end
    tick();
    checks++;
    if ((config_use_cc !== 1'b1) || (inter_lut_mux_config !== '0) || (luts_config_out !== '0)) begin
      failures++;
      $display("FAIL single_bit_fields: cc=%b mux=%b luts=%h required cc=1 mux=0 luts=0",
               config_use_cc, inter_lut_mux_config, luts_config_out);
    end
    checks++;
    if ({done, error, busy, cen} !== 4'b1000 || cen_count !== 1) begin
      failures++;
      $display("FAIL single_bit_status: done/err/busy/cen=%b cen_count=%0d required 1000 and 1",
               {done, error, busy, cen}, cen_count);
    end
  endtask

  task automatic test_parity_error();
    cen_count = 0;
    do_start();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL start_clears_done: done=%b required 0", done);
    end
    send_stream(1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if ({error, done, busy, cfg_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL parity_err_flags: err/done/busy/ready=%b required 1000",
               {error, done, busy, cfg_ready});
    end
    checks++;
    if ((cen_count !== 0) || (dut_word !== exp_word)) begin
      failures++;
      $display("FAIL parity_err_hold: cen_count=%0d word=%h required 0 and %h", cen_count,
               dut_word, exp_word);
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 3; it++) begin
      rand_stream();
      exp_word  = model_word();
      cen_count = 0;
      do_start();
      send_stream(1'b1, model_parity());
      tick();
      tick();
      checks++;
      if ((dut_word !== exp_word) || (cen_word !== exp_word)) begin
        failures++;
        $display("FAIL random_word[%0d]: out=%h captured=%h required %h", it, dut_word,
                 cen_word, exp_word);
      end
      checks++;
      if ((cen_count !== 1) || (done !== 1'b1) || (error !== 1'b0)) begin
        failures++;
        $display("FAIL random_status[%0d]: cen_count=%0d done=%b err=%b required 1 1 0", it,
                 cen_count, done, error);
      end
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({busy, done, error} !== 3'b000 || dut_word !== exp_word) begin
      failures++;
      $display("FAIL abort_over_start: busy/done/err=%b word=%h required 000 and %h",
               {busy, done, error}, dut_word, exp_word);
    end
    rand_stream();
    do_start();
    for (int k = 0; k < 70; k++) send_bit(stream[k]);
    abort     = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    abort     = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if ({busy, cfg_ready, done, error} !== 4'b0000 || dut_word !== exp_word) begin
      failures++;
      $display("FAIL abort_mid_load: busy/ready/done/err=%b word=%h required 0000 and %h",
               {busy, cfg_ready, done, error}, dut_word, exp_word);
    end
    stream.delete();
    for (int k = 0; k < P; k++) stream.push_back(1'b0);
    exp_word  = model_word();
    cen_count = 0;
    do_start();
    send_stream(1'b0, model_parity());
    tick();
    checks++;
    if ((dut_word !== exp_word) || (cen_count !== 1) || (done !== 1'b1)) begin
      failures++;
      $display("FAIL abort_reload: word=%h cen_count=%0d done=%b required %h 1 1", dut_word,
               cen_count, done, exp_word);
    end
  endtask

  task automatic test_rst_mid();
    rand_stream();
    stream[0] = 1'b1;
    exp_word  = model_word();
    do_start();
    send_stream(1'b1, model_parity());
    tick();
    checks++;
    if (dut_word !== exp_word) begin
      failures++;
      $display("FAIL pre_rst_word: got %h required %h", dut_word, exp_word);
    end
    rand_stream();
    do_start();
    for (int k = 0; k < 100; k++) send_bit(stream[k]);
    rst       = 1'b1;
    start     = 1'b1;
    abort     = 1'b1;
    cfg_valid = 1'b1;
    tick();
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_valid = 1'b0;
    exp_word  = '0;
    checks++;
    if ((dut_word !== exp_word) || ({cfg_ready, busy, cen, done, error} !== 5'b0)) begin
      failures++;
      $display("FAIL rst_mid_load: word=%h ready/busy/cen/done/err=%b required 0 and 00000",
               dut_word, {cfg_ready, busy, cen, done, error});
    end
  endtask

  task automatic test_start_ignored();
    rand_stream();
    exp_word  = model_word();
    cen_count = 0;
    accepted  = 0;
    do_start();
    for (int k = 0; k < 10; k++) send_bit(stream[k]);
    start = 1'b1;
    send_bit(stream[10]);
    start = 1'b0;
    for (int k = 11; k < P; k++) send_bit(stream[k]);
    checks++;
    if ({cfg_ready, busy, cen} !== 3'b110) begin
      failures++;
      $display("FAIL parity_wait: ready/busy/cen=%b required 110", {cfg_ready, busy, cen});
    end
    send_bit(model_parity());
    checks++;
    if ((accepted !== 140) || (cen !== 1'b1)) begin
      failures++;
      $display("FAIL start_ignored_count: accepted=%0d cen=%b required 140 and 1", accepted, cen);
    end
    tick();
    checks++;
    if ((dut_word !== exp_word) || (cen_count !== 1) || (done !== 1'b1)) begin
      failures++;
      $display("FAIL start_ignored_word: word=%h cen_count=%0d done=%b required %h 1 1",
               dut_word, cen_count, done, exp_word);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_parity_error();
    test_random_gaps();
    test_abort();
    test_rst_mid();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    checks++;
    failures++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
